// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares a single uart_tx transmitter between NUM_REQ byte producers.
// Requesters are served round-robin, one byte per grant. A granted byte is
// launched with a one-cycle uart_tx_en pulse. The next grant waits until the
// transmitter has raised and then dropped uart_tx_busy. If busy never rises
// within BUSY_TIMEOUT cycles, the byte is dropped and arb_err pulses.
//
// Parameters
//   NUM_REQ       number of requesters, 2..8
//   BUSY_TIMEOUT  cycles allowed for uart_tx_busy to rise after launch, 2..255
//
// Ports
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   req_valid     per-requester "holds a byte"
//   req_data      byte of requester i in bits [8i+7:8i]
//   req_ready     one-hot accept strobe (combinational, IDLE only)
//   uart_tx_en    one-cycle launch pulse to uart_tx
//   uart_tx_data  launched byte, stable from launch until the next accept
//   uart_tx_busy  busy flag from uart_tx
//   gnt_id        index of the last accepted requester
//   arb_busy      high whenever the FSM is not in IDLE
//   arb_err       one-cycle pulse when the busy-rise timeout expires
//
// Build option
//   UART_TX_ARB_PRIO_EN : when defined, requester 0 has fixed priority and
//   does not move the round-robin pointer; the other requesters rotate among
//   themselves. When undefined, all requesters are served pure round-robin.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 uart_tx_en,
  output logic [7:0]           uart_tx_data,
  input  logic                 uart_tx_busy,
  output logic [2:0]           gnt_id,
  output logic                 arb_busy,
  output logic                 arb_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_HI,
    ST_WAIT_LO
  } state_t;

  localparam logic [3:0] NUM_REQ_W    = 4'(NUM_REQ);
  localparam logic [2:0] LAST_REQ     = 3'(NUM_REQ - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(BUSY_TIMEOUT - 1);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t     r_state;
  logic [2:0] r_rr_ptr;
  logic [7:0] r_to_cnt;
  logic       r_tx_en;
  logic [7:0] r_tx_data;
  logic [2:0] r_gnt_id;
  logic       r_arb_err;

  // ---------------------------------------------------------------------------
  // Requester vectors widened to the 8-requester maximum so that a 3-bit
  // index always addresses them exactly, whatever NUM_REQ is.
  // ---------------------------------------------------------------------------
  logic [7:0]  w_valid_ext;
  logic [63:0] w_data_ext;

  assign w_valid_ext = 8'(req_valid);
  assign w_data_ext  = 64'(req_data);

  // ---------------------------------------------------------------------------
  // Round-robin candidates: candidate gi is requester (rr_ptr + 1 + gi) mod
  // NUM_REQ. The sum never reaches 2*NUM_REQ, so one conditional subtract
  // gives an exact wrap for non-power-of-two NUM_REQ as well.
  // ---------------------------------------------------------------------------
  logic [2:0]         w_cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] w_cand_vld;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [3:0] w_sum;
    assign w_sum          = {1'b0, r_rr_ptr} + 4'(gi + 1);
    assign w_cand_idx[gi] = (w_sum >= NUM_REQ_W) ? 3'(w_sum - NUM_REQ_W) : w_sum[2:0];
    assign w_cand_vld[gi] = w_valid_ext[w_cand_idx[gi]];
  end

  // Lowest candidate offset wins: scan from the far end so the nearest valid
  // candidate overwrites the others.
  logic [2:0] w_rr_win;

  always_comb begin
    w_rr_win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_cand_vld[k]) begin
        w_rr_win = w_cand_idx[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Winner selection and pointer update policy
  // ---------------------------------------------------------------------------
  logic [2:0] w_win;
  logic       w_ptr_upd;

`ifdef UART_TX_ARB_PRIO_EN
  // Requester 0 pre-empts the rotation and leaves the pointer untouched, so
  // the remaining requesters keep their round-robin order.
  assign w_win     = req_valid[0] ? 3'd0 : w_rr_win;
  assign w_ptr_upd = ~req_valid[0];
`else
  assign w_win     = w_rr_win;
  assign w_ptr_upd = 1'b1;
`endif

  // An accept needs an idle arbiter and an idle transmitter; a busy flag seen
  // in IDLE belongs to someone else's launch. Ready is also held low while
  // reset is asserted.
  logic w_accept;

  assign w_accept = rst_n && (r_state == ST_IDLE) && (|req_valid) && !uart_tx_busy;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready[gi] = w_accept && (w_win == 3'(gi));
  end

  logic [7:0] w_win_byte;

  assign w_win_byte = w_data_ext[{w_win, 3'b000} +: 8];

  // ---------------------------------------------------------------------------
  // FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_rr_ptr  <= LAST_REQ;
      r_to_cnt  <= '0;
      r_tx_en   <= 1'b0;
      r_tx_data <= 8'h00;
      r_gnt_id  <= 3'd0;
      r_arb_err <= 1'b0;
    end else begin
      r_tx_en   <= 1'b0;
      r_arb_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_tx_data <= w_win_byte;
            r_gnt_id  <= w_win;
            if (w_ptr_upd) begin
              r_rr_ptr <= w_win;
            end
            // Launch pulse is registered so it is high exactly in LAUNCH.
            r_tx_en <= 1'b1;
            r_state <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          r_to_cnt <= '0;
          r_state  <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (uart_tx_busy) begin
            r_state <= ST_WAIT_LO;
          end else if (r_to_cnt == TIMEOUT_LAST) begin
            // Transmitter never picked the byte up: drop it, no retry.
            r_arb_err <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 8'd1;
          end
        end
        ST_WAIT_LO: begin
          // Frame length is fixed by the baud rate, so no timeout here.
          if (!uart_tx_busy) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign uart_tx_en   = r_tx_en;
  assign uart_tx_data = r_tx_data;
  assign gnt_id       = r_gnt_id;
  assign arb_err      = r_arb_err;
  // Pure decode of the state register.
  assign arb_busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter. Two instances share clock and reset:
// u_arb4 (NUM_REQ=4) and u_arb3 (NUM_REQ=3, wrap check). Each has a small
// uart_tx busy model: busy rises the cycle after uart_tx_en and stays high
// for BUSY_LEN cycles. The 4-requester model can be made dead (never busy)
// and can have a foreign busy forced on top.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int BUSY_LEN = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;

  // 4-requester instance
  logic [3:0]  valid4 = '0;
  logic [31:0] data4  = '0;
  logic [3:0]  ready4;
  logic        en4;
  logic [7:0]  txd4;
  logic        busy4;
  logic [2:0]  gnt4;
  logic        abusy4;
  logic        err4;
  logic        mbusy4;
  logic        fbusy4 = 1'b0;
  logic        dead4  = 1'b0;
  int          bcnt4;

  // 3-requester instance
  logic [2:0]  valid3 = '0;
  logic [23:0] data3  = '0;
  logic [2:0]  ready3;
  logic        en3;
  logic [7:0]  txd3;
  logic        busy3;
  logic [2:0]  gnt3;
  logic        abusy3;
  logic        err3;
  int          bcnt3;

  assign busy4 = mbusy4 | fbusy4;

  uart_tx_arbiter #(.NUM_REQ(4), .BUSY_TIMEOUT(16)) u_arb4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (valid4),
    .req_data     (data4),
    .req_ready    (ready4),
    .uart_tx_en   (en4),
    .uart_tx_data (txd4),
    .uart_tx_busy (busy4),
    .gnt_id       (gnt4),
    .arb_busy     (abusy4),
    .arb_err      (err4)
  );

  uart_tx_arbiter #(.NUM_REQ(3), .BUSY_TIMEOUT(16)) u_arb3 (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (valid3),
    .req_data     (data3),
    .req_ready    (ready3),
    .uart_tx_en   (en3),
    .uart_tx_data (txd3),
    .uart_tx_busy (busy3),
    .gnt_id       (gnt3),
    .arb_busy     (abusy3),
    .arb_err      (err3)
  );

  // uart_tx busy models
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mbusy4 <= 1'b0;
      bcnt4  <= 0;
    end else if (en4 && !dead4) begin
      mbusy4 <= 1'b1;
      bcnt4  <= BUSY_LEN;
    end else if (mbusy4) begin
      if (bcnt4 == 1) mbusy4 <= 1'b0;
      bcnt4 <= bcnt4 - 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy3 <= 1'b0;
      bcnt3 <= 0;
    end else if (en3) begin
      busy3 <= 1'b1;
      bcnt3 <= BUSY_LEN;
    end else if (busy3) begin
      if (bcnt3 == 1) busy3 <= 1'b0;
      bcnt3 <= bcnt3 - 1;
    end
  end

  int cyc     = 0;
  int en_cnt4 = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (en4 === 1'b1) en_cnt4 <= en_cnt4 + 1;
  end

  int n_cmp = 0;
  int n_err = 0;
  int acc_cyc;

`ifdef UART_TX_ARB_PRIO_EN
  int exp2 [5] = '{0, 0, 0, 0, 0};
  int exp6 [4] = '{0, 0, 0, 1};
  int exp3 [4] = '{0, 0, 0, 0};
`else
  int exp2 [5] = '{0, 1, 2, 3, 0};
  int exp6 [4] = '{1, 0, 1, 1};
  int exp3 [4] = '{0, 2, 0, 2};
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Wait (bounded) for a valid & ready handshake; idx = -1 on timeout.
  task automatic wait_acc(input bit sel, output int idx);
    logic [3:0] hit;
    idx = -1;
    #1;
    for (int n = 0; n < 200 && idx < 0; n++) begin
      hit = sel ? {1'b0, valid3 & ready3} : (valid4 & ready4);
      if (hit != 4'b0000) begin
        for (int i = 0; i < 4; i++) if (hit[i]) idx = i;
        acc_cyc = cyc;
      end else begin
        step();
      end
    end
  endtask

  // One grant: check winner and strobe, then the launch cycle.
  task automatic serve(input bit sel, input int exp_idx, input logic [7:0] exp_byte,
                       input string tag);
    int idx;
    wait_acc(sel, idx);
    $display("accept %s: unit=%0d requester=%0d cycle=%0d", tag, sel ? 3 : 4, idx, acc_cyc);
    chk({tag, "_idx"}, idx, exp_idx);
    chk({tag, "_rdy"}, sel ? 32'(ready3) : 32'(ready4), 32'd1 << exp_idx);
    step();
    chk({tag, "_en"},   sel ? 32'(en3)  : 32'(en4),  32'd1);
    chk({tag, "_data"}, sel ? 32'(txd3) : 32'(txd4), 32'(exp_byte));
    chk({tag, "_gnt"},  sel ? 32'(gnt3) : 32'(gnt4), exp_idx);
  endtask

  task automatic wait_idle(input bit sel, input string tag);
    for (int n = 0; n < 100 && (sel ? abusy3 : abusy4) !== 1'b0; n++) step();
    chk({tag, "_idle"}, sel ? 32'(abusy3) : 32'(abusy4), 32'd0);
  endtask

  initial begin
    int prev;
    int e0;

    // ---- reset state ----
    rst_n = 1'b0;
    step(); step(); step();
    chk("rst_ready", 32'(ready4), 32'd0);
    chk("rst_en",    32'(en4),    32'd0);
    chk("rst_data",  32'(txd4),   32'h00);
    chk("rst_gnt",   32'(gnt4),   32'd0);
    chk("rst_err",   32'(err4),   32'd0);
    chk("rst_busy",  32'(abusy4), 32'd0);

    // ---- 1: single requester right after reset release ----
    valid4 = 4'b0001;
    data4  = 32'h0000_00A5;
    rst_n  = 1'b1;
    serve(1'b0, 0, 8'hA5, "t1");
    chk("t1_rdy_launch",  32'(ready4), 32'd0);
    chk("t1_busy_launch", 32'(abusy4), 32'd1);
    valid4 = 4'b0000;
    wait_idle(1'b0, "t1");

    // ---- 2: all four held, round-robin order and spacing ----
    rst_n = 1'b0;
    step();
    rst_n  = 1'b1;
    data4  = 32'h1312_1110;
    valid4 = 4'b1111;
    e0     = en_cnt4;
    prev   = 0;
    for (int k = 0; k < 5; k++) begin
      serve(1'b0, exp2[k], 8'h10 + 8'(exp2[k]), $sformatf("t2_%0d", k));
      if (k > 0) chk($sformatf("t2_space_%0d", k), acc_cyc - prev, 3 + BUSY_LEN);
      prev = acc_cyc;
    end
    valid4 = 4'b0000;
    wait_idle(1'b0, "t2");
    chk("t2_en_count", en_cnt4 - e0, 32'd5);

    // ---- 3: transmitter never goes busy -> timeout, next requester ----
    dead4  = 1'b1;
    valid4 = 4'b0110;
    serve(1'b0, 1, 8'h11, "t3");
    prev = acc_cyc;
    for (int n = 0; n < 40 && err4 !== 1'b1; n++) step();
    $display("timeout: arb_err at cycle %0d, accept at %0d", cyc, prev);
    chk("t3_err",       32'(err4),   32'd1);
    chk("t3_err_delay", cyc - prev,  32'd18);
    chk("t3_err_idle",  32'(abusy4), 32'd0);
    chk("t3_hold_data", 32'(txd4),   32'h11);
    chk("t3_next_rdy",  32'(ready4), 32'b0100);
    dead4 = 1'b0;
    step();
    chk("t3_err_pulse", 32'(err4), 32'd0);
    chk("t3_next_en",   32'(en4),  32'd1);
    chk("t3_next_data", 32'(txd4), 32'h12);
    chk("t3_next_gnt",  32'(gnt4), 32'd2);
    valid4 = 4'b0000;
    wait_idle(1'b0, "t3");

    // ---- foreign busy in IDLE blocks accepts ----
    fbusy4 = 1'b1;
    valid4 = 4'b0001;
    step(); step(); step();
    chk("fb_ready", 32'(ready4), 32'd0);
    chk("fb_busy",  32'(abusy4), 32'd0);
    chk("fb_gnt",   32'(gnt4),   32'd2);
    fbusy4 = 1'b0;
    serve(1'b0, 0, 8'h10, "fb");
    valid4 = 4'b0000;
    wait_idle(1'b0, "fb");

    // ---- 5: asynchronous reset while in WAIT_LO ----
    valid4 = 4'b0010;
    serve(1'b0, 1, 8'h11, "t5");
    step(); step();
    chk("t5_in_wait_lo", {30'd0, busy4, abusy4}, 32'b11);
    valid4 = 4'b1111;
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_ready", 32'(ready4), 32'd0);
    chk("t5_rst_en",    32'(en4),    32'd0);
    chk("t5_rst_data",  32'(txd4),   32'h00);
    chk("t5_rst_gnt",   32'(gnt4),   32'd0);
    chk("t5_rst_busy",  32'(abusy4), 32'd0);
    step();
    rst_n = 1'b1;
    serve(1'b0, 0, 8'h10, "t5_after");
    valid4 = 4'b0000;
    wait_idle(1'b0, "t5");

    // ---- 6: requesters 0 and 1 held, then 0 drops ----
    valid4 = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      serve(1'b0, exp6[k], 8'h10 + 8'(exp6[k]), $sformatf("t6_%0d", k));
      if (k == 2) valid4 = 4'b0010;
    end
    valid4 = 4'b0000;
    wait_idle(1'b0, "t6");

    // ---- 4: NUM_REQ=3, requesters 2 and 0 only (wrap) ----
    data3  = 24'hC2C1C0;
    valid3 = 3'b101;
    for (int k = 0; k < 4; k++) begin
      serve(1'b1, exp3[k], 8'hC0 + 8'(exp3[k]), $sformatf("t4_%0d", k));
    end
    valid3 = 3'b000;
    wait_idle(1'b1, "t4");
    chk("t4_err", 32'(err3), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
